// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller:
//   - scan_state_e : two-phase scan FSM state (digit lit / inter-slot gap)
//   - SEG_A..SEG_DP: bit positions inside the 8-bit segment bus
//                    {dp,g,f,e,d,c,b,a}
//   - HEX_GLYPH    : hex digit 0..F to active-high segment pattern, indexed
//                    by the digit value, bit 0 = segment a ... bit 6 = g
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    localparam int NUM_DIGITS = 4;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Standard glyphs; lower-case b and d so they differ from 8 and 0.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// ---------------------------------------------------------------------------
// seg_hex_decode
// Purely combinational hex-to-seven-segment decoder. Output is active-high;
// any pin polarity inversion happens at the output register of the top.
// Ports:
//   hex_i  in  4  hex digit value 0..F
//   seg_o  out 7  segments {g,f,e,d,c,b,a}, 1 = segment lit
// ---------------------------------------------------------------------------
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_GLYPH[hex_i];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Scan scheduler for a 4-digit multiplexed seven-segment display.
// Each digit slot is an ON phase of 2^DWELL_LOG2 cycles followed by an
// all-off gap of BLANK_CYC cycles (anti-ghosting). Within the ON phase the
// digit is only driven during the first (bright+1)/8 of the dwell. Digit
// data is taken from shadow registers which are reloaded only on the frame
// boundary (last gap cycle of slot 3), so a frame never mixes old and new
// values.
//
// Ports:
//   clk         in   1  system clock
//   RSTn        in   1  synchronous reset, active-low
//   dig_val     in  16  four hex digits, [3:0] = digit 0 (rightmost)
//   dig_dot     in   4  decimal point per digit
//   dig_ena     in   4  digit enable (0 = slot dark, timing unchanged)
//   bright      in   3  brightness 0..7, captured with the shadow load
//   upd_req     in   1  host load request, level-sensitive
//   upd_ack     out  1  one-cycle pulse the cycle after a shadow load
//   seg         out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   segcs       out  4  digit select, one-hot when lit, per CS_ACTIVE_LOW
//   frame_sync  out  1  high during the frame-boundary cycle
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DWELL_LOG2     = 10,
    parameter int BLANK_CYC      = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int CS_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [15:0] dig_val,
    input  logic [3:0]  dig_dot,
    input  logic [3:0]  dig_ena,
    input  logic [2:0]  bright,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic [7:0]  seg,
    output logic [3:0]  segcs,
    output logic        frame_sync
);

    localparam int BLK_W = $clog2(BLANK_CYC + 1);

    localparam logic [DWELL_LOG2-1:0] ON_LAST  = {DWELL_LOG2{1'b1}};
    localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(BLANK_CYC - 1);
    localparam logic [1:0]            IDX_LAST = 2'd3;

    // Pin level meaning "off"; XOR with the active-high value gives the pin.
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0] CS_OFF  = (CS_ACTIVE_LOW  != 0) ? 4'hF  : 4'h0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_e           state_q,   state_d;
    logic [1:0]            idx_q,     idx_d;
    logic [DWELL_LOG2-1:0] on_cnt_q,  on_cnt_d;
    logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;

    logic [15:0]           sh_val_q,    sh_val_d;
    logic [3:0]            sh_dot_q,    sh_dot_d;
    logic [3:0]            sh_ena_q,    sh_ena_d;
    logic [2:0]            sh_bright_q, sh_bright_d;

    logic [7:0]            seg_q,        seg_d;
    logic [3:0]            segcs_q,      segcs_d;
    logic                  upd_ack_q,    upd_ack_d;
    logic                  frame_sync_q, frame_sync_d;

    // ------------------------------------------------------------------
    // Scan FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        on_cnt_d  = on_cnt_q;
        blk_cnt_d = blk_cnt_q;

        unique case (state_q)
            ST_ON: begin
                // on_cnt wraps to 0 on the last dwell cycle by itself.
                on_cnt_d = on_cnt_q + DWELL_LOG2'(1);
                if (on_cnt_q == ON_LAST) begin
                    state_d   = ST_BLANK;
                    blk_cnt_d = '0;
                end
            end
            ST_BLANK: begin
                if (blk_cnt_q == BLK_LAST) begin
                    state_d  = ST_ON;
                    idx_d    = idx_q + 2'd1;
                    on_cnt_d = '0;
                end else begin
                    blk_cnt_d = blk_cnt_q + BLK_W'(1);
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame boundary and shadow handshake
    // ------------------------------------------------------------------
    logic boundary_now;
    logic boundary_next;
    logic load_shadow;

    assign boundary_now  = (state_q == ST_BLANK) && (idx_q == IDX_LAST) &&
                           (blk_cnt_q == BLK_LAST);
    // frame_sync is registered from the next-state view so that it is high
    // in the same cycle the FSM sits on the boundary.
    assign boundary_next = (state_d == ST_BLANK) && (idx_d == IDX_LAST) &&
                           (blk_cnt_d == BLK_LAST);
    assign load_shadow   = upd_req && boundary_now;

    always_comb begin
        sh_val_d    = sh_val_q;
        sh_dot_d    = sh_dot_q;
        sh_ena_d    = sh_ena_q;
        sh_bright_d = sh_bright_q;
        if (load_shadow) begin
            sh_val_d    = dig_val;
            sh_dot_d    = dig_dot;
            sh_ena_d    = dig_ena;
            sh_bright_d = bright;
        end
        upd_ack_d    = load_shadow;
        frame_sync_d = boundary_next;
    end

    // ------------------------------------------------------------------
    // Output datapath: mux current digit, decode, gate by enable and PWM
    // ------------------------------------------------------------------
    logic [3:0] cur_val;
    logic [6:0] glyph;
    logic       duty_ok;
    logic       lit;
    logic [7:0] seg_raw;
    logic [3:0] cs_raw;

    assign cur_val = sh_val_q[{idx_q, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .hex_i (cur_val),
        .seg_o (glyph)
    );

    // Top three bits of on_cnt split the dwell into eighths; eighth k is
    // lit when k <= bright, so bright=7 is full duty and bright=0 is 1/8.
    assign duty_ok = (on_cnt_q[DWELL_LOG2-1 -: 3] <= sh_bright_q);
    assign lit     = (state_q == ST_ON) && sh_ena_q[idx_q] && duty_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_cs
            assign cs_raw[gi] = lit && (idx_q == 2'(gi));
        end
    endgenerate

    always_comb begin
        seg_raw = '0;
        if (lit) begin
            seg_raw[SEG_A]  = glyph[SEG_A];
            seg_raw[SEG_B]  = glyph[SEG_B];
            seg_raw[SEG_C]  = glyph[SEG_C];
            seg_raw[SEG_D]  = glyph[SEG_D];
            seg_raw[SEG_E]  = glyph[SEG_E];
            seg_raw[SEG_F]  = glyph[SEG_F];
            seg_raw[SEG_G]  = glyph[SEG_G];
            seg_raw[SEG_DP] = sh_dot_q[idx_q];
        end
        seg_d   = seg_raw ^ SEG_OFF;
        segcs_d = cs_raw ^ CS_OFF;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            on_cnt_q     <= '0;
            blk_cnt_q    <= '0;
            sh_val_q     <= '0;
            sh_dot_q     <= '0;
            sh_ena_q     <= '0;
            sh_bright_q  <= 3'd7;
            seg_q        <= SEG_OFF;
            segcs_q      <= CS_OFF;
            upd_ack_q    <= 1'b0;
            frame_sync_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            on_cnt_q     <= on_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            sh_val_q     <= sh_val_d;
            sh_dot_q     <= sh_dot_d;
            sh_ena_q     <= sh_ena_d;
            sh_bright_q  <= sh_bright_d;
            seg_q        <= seg_d;
            segcs_q      <= segcs_d;
            upd_ack_q    <= upd_ack_d;
            frame_sync_q <= frame_sync_d;
        end
    end

    assign seg        = seg_q;
    assign segcs      = segcs_q;
    assign upd_ack    = upd_ack_q;
    assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Bench for seg_scan_ctrl with DWELL_LOG2=4, BLANK_CYC=2, active-low pins.
// The reference model tracks only the position inside a 72-cycle frame
// (slot k = positions 18k..18k+17, first 16 lit-capable, last 2 gap) plus
// the shadow copy of the host data; expected pins follow from that position
// one cycle later. Reset parks the scan in the gap after slot 0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam int DW_LOG2   = 4;
    localparam int BLANK     = 2;
    localparam int DWELL     = 1 << DW_LOG2;
    localparam int SLOT_LEN  = DWELL + BLANK;
    localparam int FRAME     = 4 * SLOT_LEN;
    localparam int RESET_POS = DWELL;     // gap following slot 0

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] dig_val;
    logic [3:0]  dig_dot;
    logic [3:0]  dig_ena;
    logic [2:0]  bright;
    logic        upd_req;
    logic        upd_ack;
    logic [7:0]  seg;
    logic [3:0]  segcs;
    logic        frame_sync;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DWELL_LOG2     (DW_LOG2),
        .BLANK_CYC      (BLANK),
        .SEG_ACTIVE_LOW (1),
        .CS_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .RSTn       (rstn),
        .dig_val    (dig_val),
        .dig_dot    (dig_dot),
        .dig_ena    (dig_ena),
        .bright     (bright),
        .upd_req    (upd_req),
        .upd_ack    (upd_ack),
        .seg        (seg),
        .segcs      (segcs),
        .frame_sync (frame_sync)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int          m_pos;
    logic [15:0] m_valw;
    logic [3:0]  m_dot;
    logic [3:0]  m_ena;
    logic [2:0]  m_bright;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_cs;
    logic        exp_fs;
    logic        exp_ack;

    function automatic bit m_lit(int pos);
        int slot = pos / SLOT_LEN;
        int ofs  = pos % SLOT_LEN;
        return (ofs < DWELL) && (m_ena[slot] == 1'b1) &&
               (ofs < (int'(m_bright) + 1) * DWELL / 8);
    endfunction

    function automatic logic [7:0] m_seg(int pos);
        int         slot = pos / SLOT_LEN;
        logic [3:0] nib;
        if (!m_lit(pos)) return 8'hFF;
        nib = m_valw[slot*4 +: 4];
        return ~{m_dot[slot], GLYPH[nib]};
    endfunction

    function automatic logic [3:0] m_cs(int pos);
        int         slot = pos / SLOT_LEN;
        logic [3:0] oh;
        if (!m_lit(pos)) return 4'hF;
        oh = 4'b0001 << slot;
        return ~oh;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_pos    <= RESET_POS;
            m_valw   <= '0;
            m_dot    <= '0;
            m_ena    <= '0;
            m_bright <= 3'd7;
            exp_seg  <= 8'hFF;
            exp_cs   <= 4'hF;
            exp_fs   <= 1'b0;
            exp_ack  <= 1'b0;
        end else begin
            exp_seg <= m_seg(m_pos);
            exp_cs  <= m_cs(m_pos);
            exp_ack <= (m_pos == FRAME - 1) && (upd_req === 1'b1);
            if ((m_pos == FRAME - 1) && (upd_req === 1'b1)) begin
                m_valw   <= dig_val;
                m_dot    <= dig_dot;
                m_ena    <= dig_ena;
                m_bright <= bright;
            end
            m_pos  <= (m_pos + 1) % FRAME;
            exp_fs <= ((m_pos + 1) % FRAME) == FRAME - 1;
        end
    end

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        int first_fs = -1;
        rstn = 1'b0; upd_req = 1'b0;
        dig_val = '0; dig_dot = '0; dig_ena = '0; bright = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {8'hFF, 4'hF, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: got seg=%h cs=%h fs=%b ack=%b, want FF F 0 0",
                         seg, segcs, frame_sync, upd_ack);
            end
        end
        rstn = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL reset_run k=%0d: got %h %h %b %b, want %h %h %b %b", k,
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            checks++;
            if ({seg, segcs} !== {8'hFF, 4'hF}) begin
                errors++;
                $display("FAIL reset_dark k=%0d: got seg=%h cs=%h, want FF F", k, seg, segcs);
            end
            if (frame_sync === 1'b1 && first_fs < 0) first_fs = k;
        end
        // 55 advances from the reset position reach position 71; sample k
        // follows k+1 edges.
        checks++;
        if (first_fs != FRAME - 1 - RESET_POS - 1) begin
            errors++;
            $display("FAIL reset_first_sync: got sample %0d, want %0d",
                     first_fs, FRAME - 2 - RESET_POS);
        end
    endtask

    task automatic test_load_scan();
        int n = 0;
        logic prev_fs = 1'b0;
        int cnt [4] = '{0, 0, 0, 0};
        logic [7:0] want_seg [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        logic [3:0] want_cs  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        dig_val = 16'h3210; dig_ena = 4'hF; dig_dot = 4'h0; bright = 3'd7; upd_req = 1'b1;
        while (n < 200) begin
            @(negedge clk); n++;
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL load_wait: got %h %h %b %b, want %h %h %b %b",
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            if (upd_ack === 1'b1) break;
            prev_fs = frame_sync;
        end
        checks++;
        if (upd_ack !== 1'b1 || prev_fs !== 1'b1) begin
            errors++;
            $display("FAIL load_ack: got ack=%b prev_sync=%b, want 1 1", upd_ack, prev_fs);
        end
        upd_req = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL load_scan k=%0d: got %h %h %b %b, want %h %h %b %b", k,
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            for (int d = 0; d < 4; d++)
                if (segcs === want_cs[d] && seg === want_seg[d]) cnt[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (cnt[d] != DWELL) begin
                errors++;
                $display("FAIL load_digit%0d: got %0d lit cycles, want %0d", d, cnt[d], DWELL);
            end
        end
    endtask

    task automatic test_brightness(input logic [2:0] lvl);
        int n = 0;
        int lit = 0;
        dig_val = 16'($urandom()); dig_ena = 4'hF; dig_dot = 4'($urandom());
        bright = lvl; upd_req = 1'b1;
        while (n < 200) begin
            @(negedge clk); n++;
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL bright_wait: got %h %h %b %b, want %h %h %b %b",
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            if (upd_ack === 1'b1) break;
        end
        upd_req = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL bright_scan b=%0d k=%0d: got %h %h %b %b, want %h %h %b %b", lvl, k,
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            if (segcs !== 4'hF) lit++;
        end
        // (lvl+1) eighths of each 16-cycle dwell, four slots
        checks++;
        if (lit != 4 * 2 * (int'(lvl) + 1)) begin
            errors++;
            $display("FAIL bright_duty b=%0d: got %0d lit cycles, want %0d",
                     lvl, lit, 8 * (int'(lvl) + 1));
        end
    endtask

    task automatic test_enable_dot();
        int n = 0;
        int lit = 0;
        int dp = 0;
        dig_val = 16'($urandom()); dig_ena = 4'b0101; dig_dot = 4'b0001;
        bright = 3'd7; upd_req = 1'b1;
        while (n < 200) begin
            @(negedge clk); n++;
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL ena_wait: got %h %h %b %b, want %h %h %b %b",
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            if (upd_ack === 1'b1) break;
        end
        upd_req = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL ena_scan k=%0d: got %h %h %b %b, want %h %h %b %b", k,
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            if (segcs !== 4'hF) lit++;
            if (segcs === 4'hE && seg[7] === 1'b0) dp++;
        end
        checks++;
        if (lit != 2 * DWELL || dp != DWELL) begin
            errors++;
            $display("FAIL ena_dot: got lit=%0d dp=%0d, want %0d %0d", lit, dp, 2 * DWELL, DWELL);
        end
    endtask

    task automatic test_mid_frame();
        int n = 0;
        int acks = 0;
        while (n < 200 && frame_sync !== 1'b1) begin
            @(negedge clk); n++;
        end
        // first sample after the boundary is position 0; go to position 20
        repeat (21) @(negedge clk);
        dig_val = dig_val ^ (16'($urandom()) | 16'h0001);
        dig_ena = 4'hF; dig_dot = 4'($urandom()); bright = 3'($urandom());
        upd_req = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL mid_frame k=%0d: got %h %h %b %b, want %h %h %b %b", k,
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            if (upd_ack === 1'b1) begin
                acks++;
                upd_req = 1'b0;
            end
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL mid_frame_acks: got %0d, want 1", acks);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        dig_val = 16'($urandom()); dig_ena = 4'($urandom()); dig_dot = 4'($urandom());
        bright = 3'($urandom()); upd_req = 1'b1;
        // any 144 consecutive cycles hold exactly two boundaries
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL b2b k=%0d: got %h %h %b %b, want %h %h %b %b", k,
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            if (upd_ack === 1'b1) begin
                acks++;
                dig_val = 16'($urandom()); dig_ena = 4'($urandom());
            end
        end
        upd_req = 1'b0;
        checks++;
        if (acks != 2) begin
            errors++;
            $display("FAIL b2b_acks: got %0d, want 2", acks);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int n = 0;
            dig_val = 16'($urandom()); dig_ena = 4'($urandom()); dig_dot = 4'($urandom());
            bright = 3'($urandom_range(7, 0)); upd_req = 1'b1;
            while (n < 200) begin
                @(negedge clk); n++;
                if (upd_ack === 1'b1) break;
            end
            checks++;
            if (upd_ack !== 1'b1) begin
                errors++;
                $display("FAIL random_ack it=%0d: got ack=%b, want 1", it, upd_ack);
            end
            upd_req = 1'b0;
            for (int k = 0; k < FRAME; k++) begin
                @(negedge clk);
                checks++;
                if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                    errors++;
                    $display("FAIL random it=%0d k=%0d: got %h %h %b %b, want %h %h %b %b", it, k,
                             seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int ack_at = -1;
        int dark_lit = 0;
        int lit = 0;
        while (n < 200 && frame_sync !== 1'b1) begin
            @(negedge clk); n++;
        end
        repeat (41) @(negedge clk);          // position 40: slot 2 ON
        dig_val = 16'($urandom()); dig_ena = 4'hF; dig_dot = 4'($urandom());
        bright = 3'd7; upd_req = 1'b1; rstn = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {8'hFF, 4'hF, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rst_mid_off: got seg=%h cs=%h fs=%b ack=%b, want FF F 0 0",
                         seg, segcs, frame_sync, upd_ack);
            end
        end
        rstn = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL rst_mid_wait k=%0d: got %h %h %b %b, want %h %h %b %b", k,
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            if (upd_ack === 1'b1) begin
                ack_at = k;
                break;
            end
            if (segcs !== 4'hF) dark_lit++;
        end
        upd_req = 1'b0;
        // reset position 16 -> position 0 of the next frame takes 56 edges
        checks++;
        if (ack_at != FRAME - RESET_POS - 1 || dark_lit != 0) begin
            errors++;
            $display("FAIL rst_mid_ack: got ack sample %0d lit=%0d, want %0d 0",
                     ack_at, dark_lit, FRAME - RESET_POS - 1);
        end
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            checks++;
            if ({seg, segcs, frame_sync, upd_ack} !== {exp_seg, exp_cs, exp_fs, exp_ack}) begin
                errors++;
                $display("FAIL rst_mid_scan k=%0d: got %h %h %b %b, want %h %h %b %b", k,
                         seg, segcs, frame_sync, upd_ack, exp_seg, exp_cs, exp_fs, exp_ack);
            end
            if (segcs !== 4'hF) lit++;
        end
        checks++;
        if (lit != 4 * DWELL) begin
            errors++;
            $display("FAIL rst_mid_lit: got %0d, want %0d", lit, 4 * DWELL);
        end
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_brightness(3'd0);
        test_brightness(3'd3);
        test_enable_dot();
        test_mid_frame();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
